// File: rtl/mult_pkg.sv
// Shared types and encodings for the iterative HI/LO multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam logic [1:0] MF_NONE = 2'b00;
    localparam logic [1:0] MF_LO   = 2'b01;
    localparam logic [1:0] MF_HI   = 2'b10;

endpackage

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add datapath: product register, multiplicand register and adder.
module mult_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   sum;

    // Low half starts as the multiplier and is consumed LSB first as the sum shifts in.
    always_comb begin
        sum = {1'b0, product[2*WIDTH-1:WIDTH]};
        if (product[0]) begin
            sum = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            product <= '0;
            mcand   <= '0;
        end else if (load) begin
            product <= {{WIDTH{1'b0}}, b};
            mcand   <= a;
        end else if (step) begin
            product <= {sum, product[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_unit.sv
// Iterative mult/multu unit with HI/LO registers and mfhi/mflo readout.
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startMult,
    input  logic             signedMult,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [1:0]       mfReg,
    output logic [WIDTH-1:0] hilo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    mult_state_t          state;
    mult_state_t          next_state;
    logic [CW-1:0]        count;
    logic                 neg_flag;
    logic                 load;
    logic                 step;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   result;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (startMult) next_state = RUN;
            RUN:  if (count == CW'(WIDTH - 1)) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load = 1'b0;
        step = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: load = startMult;
            RUN:  step = 1'b1;
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Magnitudes are taken as unsigned, so the most negative value maps onto itself exactly.
    always_comb begin
        a_mag = srca;
        b_mag = srcb;
        if (signedMult && srca[WIDTH-1]) a_mag = '0 - srca;
        if (signedMult && srcb[WIDTH-1]) b_mag = '0 - srcb;
    end

    mult_shift_add #(
        .WIDTH(WIDTH)
    ) u_shift_add (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .a       (a_mag),
        .b       (b_mag),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            count    <= '0;
            neg_flag <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            if (load) begin
                count    <= '0;
                neg_flag <= signedMult & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            end else if (step) begin
                count <= count + CW'(1);
            end
        end
    end

    always_comb begin
        result = product;
        if (neg_flag) result = '0 - product;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            hi <= result[2*WIDTH-1:WIDTH];
            lo <= result[WIDTH-1:0];
        end
    end

    always_comb begin
        case (mfReg)
            MF_HI:   hilo = hi;
            MF_LO:   hilo = lo;
            default: hilo = '0;
        endcase
    end

endmodule
